// File: rtl/adc_avg_pkg.sv
// Shared types and constants for the adc_avg block-averaging datapath.
// The optional offset feature is enabled by defining ADC_AVG_OFFSET_EN.
package adc_avg_pkg;

    localparam int DATA_W     = 24;
    localparam int LOG2_N_MAX = 8;

    typedef logic [0:0] ch_t;

    typedef struct packed {
        ch_t               ch;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/adc_avg_fifo.sv
// Two-entry result FIFO; entry 0 is always the head so the read port is a plain register.
// A push while full is dropped unless a pop happens in the same cycle.
module adc_avg_fifo
    import adc_avg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_l,
    input  logic        push,
    input  fifo_entry_t push_entry,
    output logic        full,
    input  logic        pop,
    output fifo_entry_t pop_entry,
    output logic        empty
);

    logic [1:0]  count;
    fifo_entry_t mem0;
    fifo_entry_t mem1;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count <= 2'd0;
            mem0  <= '0;
            mem1  <= '0;
        end else begin
            case (count)
                2'd0: begin
                    if (push) begin
                        mem0  <= push_entry;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        mem0 <= push_entry;
                    end else if (push) begin
                        mem1  <= push_entry;
                        count <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    // Full: a pop shifts the tail forward and frees room for a same-cycle push.
                    if (pop) begin
                        mem0 <= mem1;
                        if (push) begin
                            mem1 <= push_entry;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign pop_entry = mem0;

endmodule

// File: rtl/adc_avg.sv
// Per-channel block averager for a one- or two-channel ADC stream, with a 2-entry result FIFO.
// Define ADC_AVG_OFFSET_EN to add saturating per-channel offset subtraction (ports offset0/offset1).
module adc_avg
    import adc_avg_pkg::*;
#(
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              sync,
    input  logic              dual_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
`ifdef ADC_AVG_OFFSET_EN
    input  logic [DATA_W-1:0] offset0,
    input  logic [DATA_W-1:0] offset1,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic              out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              busy
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

    logic signed [ACC_W-1:0]  acc [2];
    logic        [CNT_W-1:0]  cnt [2];
    ch_t                      ch_ptr;
    logic signed [DATA_W-1:0] sample;
    logic signed [ACC_W-1:0]  sum;
    logic                     accept;
    logic                     complete;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;
    fifo_entry_t              push_entry;
    fifo_entry_t              head;

`ifdef ADC_AVG_OFFSET_EN
    logic [DATA_W-1:0]   offset_sel;
    logic signed [DATA_W:0] diff;

    assign offset_sel = ch_ptr[0] ? offset1 : offset0;

    // One guard bit is enough for the difference; clamp back into the 24-bit range.
    always_comb begin
        diff = $signed({in_data[DATA_W-1], in_data}) - $signed({offset_sel[DATA_W-1], offset_sel});
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            sample = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sample = diff[DATA_W-1:0];
        end
    end
`else
    assign sample = in_data;
`endif

    assign accept     = in_valid && !sync;
    assign complete   = accept && (cnt[ch_ptr] == LAST_CNT);
    assign sum        = acc[ch_ptr] + ACC_W'(sample);
    assign push_entry = '{ch: ch_ptr, data: DATA_W'(sum >>> LOG2_N)};
    assign pop        = !fifo_empty && out_ready;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            acc[0]  <= '0;
            acc[1]  <= '0;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
            ch_ptr  <= '0;
            overrun <= 1'b0;
        end else if (sync) begin
            acc[0]  <= '0;
            acc[1]  <= '0;
            cnt[0]  <= '0;
            cnt[1]  <= '0;
            ch_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                if (complete) begin
                    acc[ch_ptr] <= '0;
                    cnt[ch_ptr] <= '0;
                end else begin
                    acc[ch_ptr] <= sum;
                    cnt[ch_ptr] <= cnt[ch_ptr] + 1'b1;
                end
                ch_ptr <= dual_ch ? ~ch_ptr : '0;
            end
            if (complete && fifo_full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

    adc_avg_fifo u_fifo (
        .clk        (clk),
        .rst_l      (rst_l),
        .push       (complete),
        .push_entry (push_entry),
        .full       (fifo_full),
        .pop        (pop),
        .pop_entry  (head),
        .empty      (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head.data;
    assign out_ch    = head.ch[0];
    assign busy      = (cnt[0] != '0) || (cnt[1] != '0) || !fifo_empty;

endmodule

// File: tb/tb_adc_avg.sv
// Self-checking bench for adc_avg: one instance with LOG2_N=2 and one with LOG2_N=0 share stimulus.
// Honours ADC_AVG_OFFSET_EN when defined, adding offset ports and a saturation case.
module tb_adc_avg;
    import adc_avg_pkg::*;

    typedef struct packed {
        logic        ch;
        logic [23:0] data;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [23:0] data;
        logic        exp_valid;
        logic        exp_ch;
        logic [23:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        sync;
    logic        dual_ch;
    logic        in_valid;
    logic [23:0] in_data;
    logic        out_ready;
`ifdef ADC_AVG_OFFSET_EN
    logic [23:0] offset0;
    logic [23:0] offset1;
`endif
    logic [23:0] o2_data, o0_data;
    logic        o2_ch, o0_ch, o2_valid, o0_valid, o2_ovr, o0_ovr, o2_busy, o0_busy;

    always #5 clk = ~clk;

    adc_avg #(.LOG2_N(2)) dut2 (
        .clk(clk), .rst_l(rst_l), .sync(sync), .dual_ch(dual_ch),
        .in_data(in_data), .in_valid(in_valid),
`ifdef ADC_AVG_OFFSET_EN
        .offset0(offset0), .offset1(offset1),
`endif
        .out_data(o2_data), .out_ch(o2_ch), .out_valid(o2_valid), .out_ready(out_ready),
        .overrun(o2_ovr), .busy(o2_busy)
    );

    adc_avg #(.LOG2_N(0)) dut0 (
        .clk(clk), .rst_l(rst_l), .sync(sync), .dual_ch(dual_ch),
        .in_data(in_data), .in_valid(in_valid),
`ifdef ADC_AVG_OFFSET_EN
        .offset0(offset0), .offset1(offset1),
`endif
        .out_data(o0_data), .out_ch(o0_ch), .out_valid(o0_valid), .out_ready(out_ready),
        .overrun(o0_ovr), .busy(o0_busy)
    );

    // Reference model: index 0 mirrors dut2 (N=4), index 1 mirrors dut0 (N=1).
    longint m_acc [2][2];
    int     m_cnt [2][2];
    int     m_ptr [2];
    bit     m_ovr [2];
    exp_t   q2[$];
    exp_t   q0[$];
    vec_t   tbl[$];
    int     checks = 0;
    int     passed = 0;

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    function automatic int eff_sample(input int ch, input logic [23:0] d);
        int s;
        s = $signed(d);
`ifdef ADC_AVG_OFFSET_EN
        s = s - ((ch != 0) ? $signed(offset1) : $signed(offset0));
        if (s > 8388607) s = 8388607;
        if (s < -8388608) s = -8388608;
`endif
        return s;
    endfunction

    task automatic model_sync(input int k);
        for (int c = 0; c < 2; c++) begin
            m_acc[k][c] = 0;
            m_cnt[k][c] = 0;
        end
        m_ptr[k] = 0;
        m_ovr[k] = 1'b0;
    endtask

    task automatic model_reset();
        model_sync(0);
        model_sync(1);
        q2.delete();
        q0.delete();
    endtask

    task automatic model_accept(input int k, input logic [23:0] d);
        int   ch, s, l;
        exp_t e;
        l  = (k == 0) ? 2 : 0;
        ch = m_ptr[k];
        s  = eff_sample(ch, d);
        if (m_cnt[k][ch] + 1 == (1 << l)) begin
            e.ch   = ch[0];
            e.data = 24'((m_acc[k][ch] + longint'(s)) >>> l);
            if (k == 0) begin
                if (q2.size() < 2) q2.push_back(e); else m_ovr[k] = 1'b1;
            end else begin
                if (q0.size() < 2) q0.push_back(e); else m_ovr[k] = 1'b1;
            end
            m_acc[k][ch] = 0;
            m_cnt[k][ch] = 0;
        end else begin
            m_acc[k][ch] += longint'(s);
            m_cnt[k][ch]++;
        end
        m_ptr[k] = dual_ch ? 1 - ch : 0;
    endtask

    // Compare current DUT outputs to the model, and retire the head if the consumer takes it.
    task automatic check_output(input int k);
        logic        v, c, ov, bz, bz_exp;
        logic [23:0] d;
        exp_t        e;
        int          sz;
        string       tag;
        tag = (k == 0) ? "L2" : "L0";
        if (k == 0) begin
            v = o2_valid; c = o2_ch; d = o2_data; ov = o2_ovr; bz = o2_busy; sz = q2.size();
        end else begin
            v = o0_valid; c = o0_ch; d = o0_data; ov = o0_ovr; bz = o0_busy; sz = q0.size();
        end
        e = '0;
        if (sz != 0) e = (k == 0) ? q2[0] : q0[0];
        bz_exp = (m_cnt[k][0] != 0) || (m_cnt[k][1] != 0) || (sz != 0);
        check_value({tag, " out_valid"}, 32'(v), 32'(sz != 0));
        check_value({tag, " overrun"}, 32'(ov), 32'(m_ovr[k]));
        check_value({tag, " busy"}, 32'(bz), 32'(bz_exp));
        if (sz != 0) begin
            check_value({tag, " out_ch"}, 32'(c), 32'(e.ch));
            check_value({tag, " out_data"}, 32'(d), 32'(e.data));
            if (out_ready) begin
                if (k == 0) q2.delete(0); else q0.delete(0);
            end
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [23:0] d, input logic s);
        check_output(0);
        check_output(1);
        for (int k = 0; k < 2; k++) begin
            if (s) model_sync(k);
            else if (v) model_accept(k, d);
        end
        in_valid = v;
        in_data  = d;
        sync     = s;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sync     = 1'b0;
    endtask

    function automatic vec_t mk(input logic v, input logic [23:0] d,
                                input logic ev, input logic ec, input logic [23:0] ed);
        vec_t r;
        r.valid = v; r.data = d; r.exp_valid = ev; r.exp_ch = ec; r.exp_data = ed;
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_value({tag, " L2 out_valid"}, 32'(o2_valid), 32'(0));
        check_value({tag, " L2 out_data"}, 32'(o2_data), 32'(0));
        check_value({tag, " L2 out_ch"}, 32'(o2_ch), 32'(0));
        check_value({tag, " L2 overrun"}, 32'(o2_ovr), 32'(0));
        check_value({tag, " L2 busy"}, 32'(o2_busy), 32'(0));
        check_value({tag, " L0 out_valid"}, 32'(o0_valid), 32'(0));
        check_value({tag, " L0 out_data"}, 32'(o0_data), 32'(0));
        check_value({tag, " L0 out_ch"}, 32'(o0_ch), 32'(0));
        check_value({tag, " L0 overrun"}, 32'(o0_ovr), 32'(0));
        check_value({tag, " L0 busy"}, 32'(o0_busy), 32'(0));
    endtask

    initial begin
        rst_l = 1'b0; sync = 1'b0; dual_ch = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef ADC_AVG_OFFSET_EN
        offset0 = '0; offset1 = '0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_l = 1'b1;

        // Interleaved two-channel averages with hand-computed results for the N=4 instance.
        tbl.push_back(mk(1, 24'h000004, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'hFFFFFF, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'h000008, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'hFFFFFE, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'h00000C, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'hFFFFFD, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'h000010, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'hFFFFFC, 1, 0, 24'h00000A));
        tbl.push_back(mk(0, 24'h000000, 1, 1, 24'hFFFFFD));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'hFFFFFF, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'h000007, 0, 0, 24'h0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 24'h000000, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'h000000, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'h000000, 1, 0, 24'hFFFFFF));
        tbl.push_back(mk(0, 24'h000000, 1, 1, 24'h000001));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 24'h0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(mk(1, 24'h800000, 0, 0, 24'h0));
            tbl.push_back(mk(1, 24'h7FFFFF, 0, 0, 24'h0));
        end
        tbl.push_back(mk(1, 24'h800000, 0, 0, 24'h0));
        tbl.push_back(mk(1, 24'h7FFFFF, 1, 0, 24'h800000));
        tbl.push_back(mk(0, 24'h000000, 1, 1, 24'h7FFFFF));
        tbl.push_back(mk(0, 24'h000000, 0, 0, 24'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            check_value($sformatf("tbl[%0d] valid", i), 32'(o2_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check_value($sformatf("tbl[%0d] ch", i), 32'(o2_ch), 32'(tbl[i].exp_ch));
                check_value($sformatf("tbl[%0d] data", i), 32'(o2_data), 32'(tbl[i].exp_data));
            end
            apply_stimulus(tbl[i].valid, tbl[i].data, 1'b0);
        end

        // Pass-through of the most negative sample with one-cycle latency.
        dual_ch = 1'b0;
        apply_stimulus(0, 24'h0, 1);
        apply_stimulus(1, 24'h800000, 0);
        check_value("passthru valid", 32'(o0_valid), 32'(1));
        check_value("passthru data", 32'(o0_data), 32'(24'h800000));
        check_value("passthru ch", 32'(o0_ch), 32'(0));
        apply_stimulus(0, 24'h0, 0);

        // Stalled consumer: two results held in order, third dropped, sync clears overrun.
        out_ready = 1'b0;
        apply_stimulus(1, 24'h000011, 0);
        apply_stimulus(1, 24'h000022, 0);
        apply_stimulus(1, 24'h000033, 0);
        check_value("stall overrun", 32'(o0_ovr), 32'(1));
        check_value("stall head", 32'(o0_data), 32'(24'h000011));
        apply_stimulus(0, 24'h0, 0);
        out_ready = 1'b1;
        repeat (3) apply_stimulus(0, 24'h0, 0);
        apply_stimulus(0, 24'h0, 1);
        check_value("sync clears overrun", 32'(o0_ovr), 32'(0));

        // Push and pop together on a full FIFO.
        out_ready = 1'b0;
        apply_stimulus(1, 24'h000044, 0);
        apply_stimulus(1, 24'h000055, 0);
        out_ready = 1'b1;
        apply_stimulus(1, 24'h000066, 0);
        check_value("full push+pop overrun", 32'(o0_ovr), 32'(0));
        repeat (3) apply_stimulus(0, 24'h0, 0);

        // Sync coincident with a sample discards it and restarts averaging.
        apply_stimulus(0, 24'h0, 1);
        apply_stimulus(1, 24'h000064, 0);
        apply_stimulus(1, 24'h0000C8, 0);
        apply_stimulus(1, 24'h7FFFFF, 1);
        apply_stimulus(1, 24'h000004, 0);
        apply_stimulus(1, 24'h000004, 0);
        apply_stimulus(1, 24'h000008, 0);
        apply_stimulus(1, 24'h000008, 0);
        check_value("post-sync avg valid", 32'(o2_valid), 32'(1));
        check_value("post-sync avg data", 32'(o2_data), 32'(24'h000006));
        apply_stimulus(0, 24'h0, 0);
        apply_stimulus(0, 24'h0, 0);

`ifdef ADC_AVG_OFFSET_EN
        // Offset subtraction saturates at the negative rail.
        apply_stimulus(0, 24'h0, 1);
        offset0 = 24'h000001;
        apply_stimulus(1, 24'h800000, 0);
        check_value("offset sat data", 32'(o0_data), 32'(24'h800000));
        apply_stimulus(0, 24'h0, 0);
        offset0 = 24'h000000;
        apply_stimulus(0, 24'h0, 1);
`endif

        // Reset mid-accumulation with one result queued.
        out_ready = 1'b0;
        apply_stimulus(1, 24'h000055, 0);
        #2;
        rst_l = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_l     = 1'b1;
        dual_ch   = 1'b1;
        out_ready = 1'b1;
        apply_stimulus(0, 24'h0, 0);
        apply_stimulus(0, 24'h0, 0);
        apply_stimulus(1, 24'h000077, 0);
        check_value("first after reset ch", 32'(o0_ch), 32'(0));
        check_value("first after reset data", 32'(o0_data), 32'(24'h000077));
        apply_stimulus(1, 24'h000088, 0);
        repeat (3) apply_stimulus(0, 24'h0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
